// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin bus arbiter with per-master request
// capture and a BUSY-cycle watchdog that aborts transactions the slave
// never acknowledges.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_stb,
    input  logic [3:0]  i_m0_we,
    input  logic [31:0] i_m0_dat_w,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_stb,
    input  logic [3:0]  i_m1_we,
    input  logic [31:0] i_m1_dat_w,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_s_addr,
    output logic        o_s_stb,
    output logic [3:0]  o_s_we,
    output logic [31:0] o_s_dat_w,
    input  logic        i_s_ack,
    input  logic [31:0] i_s_dat_r,
    output logic [31:0] o_m_dat_r
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [1:0]  pend;
    logic [1:0]  pend_eff;
    logic [31:0] cap_addr [2];
    logic [3:0]  cap_we   [2];
    logic [31:0] cap_dat  [2];
    logic [31:0] in_addr  [2];
    logic [3:0]  in_we    [2];
    logic [31:0] in_dat   [2];
    logic [1:0]  in_stb;
    logic        gnt;
    logic        last;
    logic        pick;
    logic [7:0]  cnt;
    logic        tmo;
    logic        done;

    assign in_stb     = {i_m1_stb, i_m0_stb};
    assign in_addr[0] = i_m0_addr;
    assign in_addr[1] = i_m1_addr;
    assign in_we[0]   = i_m0_we;
    assign in_we[1]   = i_m1_we;
    assign in_dat[0]  = i_m0_dat_w;
    assign in_dat[1]  = i_m1_dat_w;

    // Watchdog fires on the TIMEOUT-th BUSY cycle (counter is 0 on the first)
    assign tmo  = (state == BUSY) && (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT));
    // A slave ack wins over a coincident timeout; reset suppresses completion
    assign done = (state == BUSY) && !i_rst && (i_s_ack || tmo);

    assign o_m0_ack  = done && !gnt;
    assign o_m1_ack  = done && gnt;
    assign o_m0_err  = o_m0_ack && !i_s_ack;
    assign o_m1_err  = o_m1_ack && !i_s_ack;
    assign o_m_dat_r = i_s_dat_r;

    // Round-robin: on a tie the master not granted last time wins
    assign pick = (&pend) ? ~last : pend[1];

    // Pending view after this cycle's completion, so the finishing master can re-request at once
    always_comb begin
        pend_eff = pend;
        if (done) pend_eff[gnt] = 1'b0;
    end

    // Pending flags: set by an accepted stb, cleared on completion or reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend <= 2'b00;
        end else begin
            for (int m = 0; m < 2; m++) begin
                pend[m] <= pend_eff[m] | in_stb[m];
            end
        end
    end

    // Request capture; an stb while still pending is dropped
    always_ff @(posedge i_clk) begin
        for (int m = 0; m < 2; m++) begin
            if (in_stb[m] && !pend_eff[m]) begin
                cap_addr[m] <= in_addr[m];
                cap_we[m]   <= in_we[m];
                cap_dat[m]  <= in_dat[m];
            end
        end
    end

    // Arbitration FSM with registered slave-side request outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            last      <= 1'b1;
            gnt       <= 1'b0;
            o_s_stb   <= 1'b0;
            o_s_we    <= 4'd0;
            o_s_addr  <= 32'd0;
            o_s_dat_w <= 32'd0;
        end else begin
            o_s_stb <= 1'b0;
            o_s_we  <= 4'd0;
            case (state)
                IDLE: begin
                    if (|pend) begin
                        gnt       <= pick;
                        o_s_stb   <= 1'b1;
                        o_s_we    <= cap_we[pick];
                        o_s_addr  <= cap_addr[pick];
                        o_s_dat_w <= cap_dat[pick];
                        cnt       <= 8'd0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last  <= gnt;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule
